// File: rtl/fpu_issue_scoreboard.sv
// FP issue stage with an integrated register file, per-register busy scoreboard and tagged
// out-of-order writeback. Up to MAX_OUT operations may be in flight at once.
module fpu_issue_scoreboard #(
    parameter int unsigned FPLEN   = 16,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned MAX_OUT = 4,
    localparam int unsigned AW = $clog2(NREGS),
    localparam int unsigned TW = $clog2(MAX_OUT),
    localparam int unsigned OW = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             flush,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [2:0]       dec_rden,
    input  logic [AW-1:0]    dec_fs1,
    input  logic [AW-1:0]    dec_fs2,
    input  logic [AW-1:0]    dec_fs3,
    input  logic [AW-1:0]    dec_fd,
    input  logic             dec_fd_we,
    input  logic [23:0]      dec_op,
    input  logic [2:0]       dec_rnd,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [TW-1:0]    iss_tag,
    output logic [FPLEN-1:0] iss_fs1,
    output logic [FPLEN-1:0] iss_fs2,
    output logic [FPLEN-1:0] iss_fs3,
    output logic [23:0]      iss_op,
    output logic [2:0]       iss_rnd,
    input  logic             wb_valid,
    input  logic [TW-1:0]    wb_tag,
    input  logic [FPLEN-1:0] wb_data,
    output logic             wb_err,
    output logic [OW-1:0]    outstanding
);

    logic [FPLEN-1:0]   r_regs [NREGS];
    logic [NREGS-1:0]   r_busy;
    logic [MAX_OUT-1:0] r_tag_valid;
    logic [AW-1:0]      r_tag_fd [MAX_OUT];
    logic [MAX_OUT-1:0] r_tag_we;

    logic               r_iss_valid;
    logic [TW-1:0]      r_iss_tag;
    logic [FPLEN-1:0]   r_iss_fs1;
    logic [FPLEN-1:0]   r_iss_fs2;
    logic [FPLEN-1:0]   r_iss_fs3;
    logic [23:0]        r_iss_op;
    logic [2:0]         r_iss_rnd;
    logic               r_wb_err;
    logic [OW-1:0]      r_outstanding;

    logic               w_wb_hit;
    logic [AW-1:0]      w_wb_fd;
    logic               w_wb_we;
    logic               w_wb_live;
    logic               w_wb_wr;
    logic               w_byp1;
    logic               w_byp2;
    logic               w_byp3;
    logic               w_raw;
    logic               w_waw;
    logic               w_tag_free;
    logic [TW-1:0]      w_free_tag;
    logic               w_accept;
    logic [FPLEN-1:0]   w_op1;
    logic [FPLEN-1:0]   w_op2;
    logic [FPLEN-1:0]   w_op3;
    logic [NREGS-1:0]   w_busy_d;
    logic [MAX_OUT-1:0] w_tag_valid_d;
    logic [OW-1:0]      w_out_d;

    // Tag table lookup for the returning result; out-of-range tags simply miss.
    always_comb begin
        w_wb_hit = 1'b0;
        w_wb_fd  = '0;
        w_wb_we  = 1'b0;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (wb_tag == TW'(i) && r_tag_valid[i]) begin
                w_wb_hit = 1'b1;
                w_wb_fd  = r_tag_fd[i];
                w_wb_we  = r_tag_we[i];
            end
        end
    end

    assign w_wb_live = wb_valid & w_wb_hit & ~flush;
    assign w_wb_wr   = wb_valid & w_wb_hit & w_wb_we;

    assign w_byp1 = w_wb_wr & (w_wb_fd == dec_fs1);
    assign w_byp2 = w_wb_wr & (w_wb_fd == dec_fs2);
    assign w_byp3 = w_wb_wr & (w_wb_fd == dec_fs3);

    assign w_raw = (dec_rden[0] & r_busy[dec_fs1] & ~w_byp1) |
                   (dec_rden[1] & r_busy[dec_fs2] & ~w_byp2) |
                   (dec_rden[2] & r_busy[dec_fs3] & ~w_byp3);
    assign w_waw = dec_fd_we & r_busy[dec_fd];

    always_comb begin
        w_tag_free = 1'b0;
        w_free_tag = '0;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (!r_tag_valid[i] && !w_tag_free) begin
                w_tag_free = 1'b1;
                w_free_tag = TW'(i);
            end
        end
    end

    assign dec_ready = rst_l & ~flush & ~w_raw & ~w_waw & w_tag_free &
                       (~r_iss_valid | iss_ready);
    assign w_accept  = dec_valid & dec_ready;

    assign w_op1 = !dec_rden[0] ? '0 : (w_byp1 ? wb_data : r_regs[dec_fs1]);
    assign w_op2 = !dec_rden[1] ? '0 : (w_byp2 ? wb_data : r_regs[dec_fs2]);
    assign w_op3 = !dec_rden[2] ? '0 : (w_byp3 ? wb_data : r_regs[dec_fs3]);

    // A busy dec_fd stalls on WAW, so the clear and the set never target the same bit.
    always_comb begin
        w_busy_d = r_busy;
        if (w_wb_live && w_wb_we) begin
            w_busy_d[w_wb_fd] = 1'b0;
        end
        if (w_accept && dec_fd_we) begin
            w_busy_d[dec_fd] = 1'b1;
        end
    end

    always_comb begin
        w_tag_valid_d = r_tag_valid;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (w_wb_live && wb_tag == TW'(i)) begin
                w_tag_valid_d[i] = 1'b0;
            end
            if (w_accept && w_free_tag == TW'(i)) begin
                w_tag_valid_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_out_d = r_outstanding;
        if (w_accept && !w_wb_live) begin
            w_out_d = r_outstanding + OW'(1);
        end else if (!w_accept && w_wb_live) begin
            w_out_d = r_outstanding - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            for (int i = 0; i < MAX_OUT; i++) begin
                r_tag_fd[i] <= '0;
            end
            r_busy        <= '0;
            r_tag_valid   <= '0;
            r_tag_we      <= '0;
            r_iss_valid   <= 1'b0;
            r_iss_tag     <= '0;
            r_iss_fs1     <= '0;
            r_iss_fs2     <= '0;
            r_iss_fs3     <= '0;
            r_iss_op      <= '0;
            r_iss_rnd     <= '0;
            r_wb_err      <= 1'b0;
            r_outstanding <= '0;
        end else if (flush) begin
            r_busy        <= '0;
            r_tag_valid   <= '0;
            r_iss_valid   <= 1'b0;
            r_wb_err      <= 1'b0;
            r_outstanding <= '0;
        end else begin
            r_wb_err      <= wb_valid & ~w_wb_hit;
            r_busy        <= w_busy_d;
            r_tag_valid   <= w_tag_valid_d;
            r_outstanding <= w_out_d;
            if (w_wb_live && w_wb_we) begin
                r_regs[w_wb_fd] <= wb_data;
            end
            if (w_accept) begin
                r_tag_fd[w_free_tag] <= dec_fd;
                r_tag_we[w_free_tag] <= dec_fd_we;
                r_iss_valid          <= 1'b1;
                r_iss_tag            <= w_free_tag;
                r_iss_fs1            <= w_op1;
                r_iss_fs2            <= w_op2;
                r_iss_fs3            <= w_op3;
                r_iss_op             <= dec_op;
                r_iss_rnd            <= dec_rnd;
            end else if (iss_ready) begin
                r_iss_valid <= 1'b0;
            end
        end
    end

    assign iss_valid   = r_iss_valid;
    assign iss_tag     = r_iss_tag;
    assign iss_fs1     = r_iss_fs1;
    assign iss_fs2     = r_iss_fs2;
    assign iss_fs3     = r_iss_fs3;
    assign iss_op      = r_iss_op;
    assign iss_rnd     = r_iss_rnd;
    assign wb_err      = r_wb_err;
    assign outstanding = r_outstanding;

endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// Bench for fpu_issue_scoreboard: directed scenarios followed by random traffic, every cycle
// checked against a transaction-level model of registers, busy bits and the tag table.
module tb_fpu_issue_scoreboard;

    localparam int FPLEN   = 16;
    localparam int NREGS   = 32;
    localparam int MAX_OUT = 4;
    localparam int AW      = 5;
    localparam int TW      = 2;
    localparam int OW      = 3;

    logic             clk = 1'b0;
    logic             rst_l = 1'b0;
    logic             flush = 1'b0;
    logic             dec_valid = 1'b0;
    logic             dec_ready;
    logic [2:0]       dec_rden = '0;
    logic [AW-1:0]    dec_fs1 = '0;
    logic [AW-1:0]    dec_fs2 = '0;
    logic [AW-1:0]    dec_fs3 = '0;
    logic [AW-1:0]    dec_fd = '0;
    logic             dec_fd_we = 1'b0;
    logic [23:0]      dec_op = '0;
    logic [2:0]       dec_rnd = '0;
    logic             iss_valid;
    logic             iss_ready = 1'b1;
    logic [TW-1:0]    iss_tag;
    logic [FPLEN-1:0] iss_fs1;
    logic [FPLEN-1:0] iss_fs2;
    logic [FPLEN-1:0] iss_fs3;
    logic [23:0]      iss_op;
    logic [2:0]       iss_rnd;
    logic             wb_valid = 1'b0;
    logic [TW-1:0]    wb_tag = '0;
    logic [FPLEN-1:0] wb_data = '0;
    logic             wb_err;
    logic [OW-1:0]    outstanding;

    always #5 clk = ~clk;

    fpu_issue_scoreboard #(
        .FPLEN  (FPLEN),
        .NREGS  (NREGS),
        .MAX_OUT(MAX_OUT)
    ) u_dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .flush      (flush),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_rden   (dec_rden),
        .dec_fs1    (dec_fs1),
        .dec_fs2    (dec_fs2),
        .dec_fs3    (dec_fs3),
        .dec_fd     (dec_fd),
        .dec_fd_we  (dec_fd_we),
        .dec_op     (dec_op),
        .dec_rnd    (dec_rnd),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_tag    (iss_tag),
        .iss_fs1    (iss_fs1),
        .iss_fs2    (iss_fs2),
        .iss_fs3    (iss_fs3),
        .iss_op     (iss_op),
        .iss_rnd    (iss_rnd),
        .wb_valid   (wb_valid),
        .wb_tag     (wb_tag),
        .wb_data    (wb_data),
        .wb_err     (wb_err),
        .outstanding(outstanding)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic obs_ready = 1'b0;

    // Reference model: architectural registers, busy set and in-flight table.
    logic [FPLEN-1:0] m_regs [NREGS];
    bit               m_busy [NREGS];
    bit               m_tv   [MAX_OUT];
    int               m_tfd  [MAX_OUT];
    bit               m_twe  [MAX_OUT];
    bit               m_iv;
    int               m_itag;
    logic [FPLEN-1:0] m_if1, m_if2, m_if3;
    logic [23:0]      m_iop;
    logic [2:0]       m_irnd;
    bit               m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_wb_writes(input int r);
        return wb_valid && m_tv[wb_tag] && m_twe[wb_tag] && m_tfd[wb_tag] == r;
    endfunction

    function automatic logic [FPLEN-1:0] m_opnd(input bit en, input int r);
        if (!en) return '0;
        if (m_wb_writes(r)) return wb_data;
        return m_regs[r];
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < MAX_OUT; i++) if (m_tv[i]) n++;
        return n;
    endfunction

    function automatic bit m_ready();
        int src [3];
        bit any_free = 0;
        src[0] = int'(dec_fs1);
        src[1] = int'(dec_fs2);
        src[2] = int'(dec_fs3);
        if (!rst_l || flush) return 0;
        for (int i = 0; i < 3; i++)
            if (dec_rden[i] && m_busy[src[i]] && !m_wb_writes(src[i])) return 0;
        if (dec_fd_we && m_busy[dec_fd]) return 0;
        if (m_iv && !iss_ready) return 0;
        for (int i = 0; i < MAX_OUT; i++) if (!m_tv[i]) any_free = 1;
        return any_free;
    endfunction

    task automatic m_tick();
        bit exp_rdy, acc, hit;
        int t;
        exp_rdy = m_ready();
        obs_ready = dec_ready;
        chk("dec_ready", 64'(dec_ready), 64'(exp_rdy));
        if (!rst_l) begin
            for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
            for (int i = 0; i < MAX_OUT; i++) m_tv[i] = 0;
            m_iv = 0;
            m_err = 0;
            return;
        end
        if (flush) begin
            for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
            for (int i = 0; i < MAX_OUT; i++) m_tv[i] = 0;
            m_iv = 0;
            m_err = 0;
            return;
        end
        acc = dec_valid && exp_rdy;
        hit = wb_valid && m_tv[wb_tag];
        m_err = wb_valid && !hit;
        t = 0;
        if (acc) begin
            for (int i = MAX_OUT - 1; i >= 0; i--) if (!m_tv[i]) t = i;
            m_iv   = 1;
            m_itag = t;
            m_if1  = m_opnd(dec_rden[0], int'(dec_fs1));
            m_if2  = m_opnd(dec_rden[1], int'(dec_fs2));
            m_if3  = m_opnd(dec_rden[2], int'(dec_fs3));
            m_iop  = dec_op;
            m_irnd = dec_rnd;
        end else if (iss_ready) begin
            m_iv = 0;
        end
        if (hit) begin
            if (m_twe[wb_tag]) begin
                m_regs[m_tfd[wb_tag]] = wb_data;
                m_busy[m_tfd[wb_tag]] = 0;
            end
            m_tv[wb_tag] = 0;
        end
        if (acc) begin
            m_tv[t]  = 1;
            m_tfd[t] = int'(dec_fd);
            m_twe[t] = dec_fd_we;
            if (dec_fd_we) m_busy[dec_fd] = 1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        m_tick();
        @(posedge clk);
        #1;
        chk("iss_valid", 64'(iss_valid), 64'(m_iv));
        chk("outstanding", 64'(outstanding), 64'(m_count()));
        chk("wb_err", 64'(wb_err), 64'(m_err));
        if (m_iv) begin
            chk("iss_tag", 64'(iss_tag), 64'(m_itag));
            chk("iss_fs1", 64'(iss_fs1), 64'(m_if1));
            chk("iss_fs2", 64'(iss_fs2), 64'(m_if2));
            chk("iss_fs3", 64'(iss_fs3), 64'(m_if3));
            chk("iss_op", 64'(iss_op), 64'(m_iop));
            chk("iss_rnd", 64'(iss_rnd), 64'(m_irnd));
        end
    endtask

    task automatic set_op(input int fd, input bit we, input logic [2:0] rden,
                          input int s1, input int s2, input int s3);
        dec_valid = 1'b1;
        dec_fd    = AW'(fd);
        dec_fd_we = we;
        dec_rden  = rden;
        dec_fs1   = AW'(s1);
        dec_fs2   = AW'(s2);
        dec_fs3   = AW'(s3);
        dec_op    = 24'(fd + 32'h100);
        dec_rnd   = 3'(fd);
    endtask

    task automatic wb(input int tag, input logic [FPLEN-1:0] data);
        wb_valid = 1'b1;
        wb_tag   = TW'(tag);
        wb_data  = data;
    endtask

    initial begin
        // Reset held for two cycles.
        step();
        step();
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_iss_fs1", 64'(iss_fs1), 64'd0);
        chk("rst_dec_ready", 64'(obs_ready), 64'd0);

        // Release with an independent op, then fill all four tags back to back.
        rst_l = 1'b1;
        iss_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_op(i, 1, 3'b000, 0, 0, 0);
            step();
            chk("b2b_ready", 64'(obs_ready), 64'd1);
            chk("b2b_tag", 64'(iss_tag), 64'(i - 1));
        end
        set_op(5, 1, 3'b000, 0, 0, 0);
        step();
        chk("full_stall", 64'(obs_ready), 64'd0);
        chk("full_out", 64'(outstanding), 64'd4);
        wb(2, 16'h1234);
        step();
        chk("full_wb_cycle", 64'(obs_ready), 64'd0);
        wb_valid = 1'b0;
        step();
        chk("freed_accept", 64'(obs_ready), 64'd1);
        chk("freed_tag", 64'(iss_tag), 64'd2);
        dec_valid = 1'b0;
        wb(0, 16'h0001); step();
        wb(1, 16'h0002); step();
        wb(3, 16'h0004); step();
        wb(2, 16'h0005); step();
        wb_valid = 1'b0;
        chk("drain_out", 64'(outstanding), 64'd0);

        // RAW bypass.
        set_op(5, 1, 3'b000, 0, 0, 0); step();
        set_op(6, 1, 3'b001, 5, 0, 0); step();
        chk("raw_stall", 64'(obs_ready), 64'd0);
        step();
        wb(0, 16'h3C00);
        step();
        chk("raw_bypass_ready", 64'(obs_ready), 64'd1);
        chk("raw_bypass_fs1", 64'(iss_fs1), 64'h3C00);
        chk("raw_bypass_tag", 64'(iss_tag), 64'd1);
        dec_valid = 1'b0;
        wb(1, 16'h4000); step();
        wb_valid = 1'b0;

        // WAW on f7.
        set_op(7, 1, 3'b000, 0, 0, 0); step();
        set_op(7, 1, 3'b000, 0, 0, 0); step();
        chk("waw_stall", 64'(obs_ready), 64'd0);
        wb(0, 16'h1111); step();
        chk("waw_no_bypass", 64'(obs_ready), 64'd0);
        wb_valid = 1'b0; step();
        chk("waw_accept", 64'(obs_ready), 64'd1);
        dec_valid = 1'b0;
        wb(0, 16'h2222); step();
        wb_valid = 1'b0;
        set_op(0, 0, 3'b001, 7, 0, 0); step();
        chk("waw_final_f7", 64'(iss_fs1), 64'h2222);
        dec_valid = 1'b0;
        wb(0, 16'h0bad); step();
        wb_valid = 1'b0;

        // Backpressure, then out-of-order completion.
        set_op(8, 1, 3'b000, 0, 0, 0); step();
        set_op(9, 1, 3'b000, 0, 0, 0); step();
        set_op(10, 1, 3'b000, 0, 0, 0);
        iss_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ready", 64'(obs_ready), 64'd0);
            chk("bp_tag", 64'(iss_tag), 64'd1);
            chk("bp_op", 64'(iss_op), 64'h109);
        end
        iss_ready = 1'b1;
        step();
        chk("bp_release_tag", 64'(iss_tag), 64'd2);
        dec_valid = 1'b0;
        wb(1, 16'hAAAA); step();
        wb(0, 16'hBBBB); step();
        wb(2, 16'hCCCC); step();
        wb_valid = 1'b0;
        chk("ooo_out", 64'(outstanding), 64'd0);
        set_op(0, 0, 3'b011, 8, 9, 7); step();
        chk("ooo_f8", 64'(iss_fs1), 64'hBBBB);
        chk("ooo_f9", 64'(iss_fs2), 64'hAAAA);
        chk("disabled_fs3", 64'(iss_fs3), 64'd0);
        dec_valid = 1'b0;
        wb(0, 16'h0); step();

        // Writeback to an unallocated tag.
        wb(3, 16'hDEAD); step();
        chk("err_pulse", 64'(wb_err), 64'd1);
        wb_valid = 1'b0; step();
        chk("err_one_cycle", 64'(wb_err), 64'd0);
        set_op(0, 0, 3'b001, 8, 0, 0); step();
        chk("err_no_write", 64'(iss_fs1), 64'hBBBB);
        dec_valid = 1'b0;
        wb(0, 16'h0); step();
        wb_valid = 1'b0;

        // Flush with three in flight and a simultaneous writeback.
        set_op(11, 1, 3'b000, 0, 0, 0); step();
        set_op(12, 1, 3'b000, 0, 0, 0); step();
        set_op(13, 1, 3'b000, 0, 0, 0); step();
        set_op(14, 1, 3'b000, 0, 0, 0);
        flush = 1'b1;
        wb(0, 16'h7777);
        step();
        chk("flush_ready", 64'(obs_ready), 64'd0);
        chk("flush_out", 64'(outstanding), 64'd0);
        chk("flush_iss_valid", 64'(iss_valid), 64'd0);
        chk("flush_no_err", 64'(wb_err), 64'd0);
        flush = 1'b0;
        wb_valid = 1'b0;
        set_op(12, 1, 3'b011, 11, 7, 0); step();
        chk("flush_busy_clear", 64'(obs_ready), 64'd1);
        chk("flush_f11_kept", 64'(iss_fs1), 64'd0);
        chk("flush_f7_kept", 64'(iss_fs2), 64'h2222);
        dec_valid = 1'b0;
        wb(2, 16'h5555); step();
        chk("flush_old_tag_err", 64'(wb_err), 64'd1);
        wb_valid = 1'b0;
        flush = 1'b1; step();
        flush = 1'b0;

        // Random traffic on a small register window to provoke hazards.
        for (int c = 0; c < 1500; c++) begin
            dec_valid = ($urandom_range(0, 9) < 7);
            dec_rden  = 3'($urandom_range(0, 7));
            dec_fs1   = AW'($urandom_range(0, 7));
            dec_fs2   = AW'($urandom_range(0, 7));
            dec_fs3   = AW'($urandom_range(0, 7));
            dec_fd    = AW'($urandom_range(0, 7));
            dec_fd_we = ($urandom_range(0, 3) != 0);
            dec_op    = 24'($urandom);
            dec_rnd   = 3'($urandom);
            iss_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 9) < 4);
            wb_tag    = TW'($urandom_range(0, MAX_OUT - 1));
            wb_data   = FPLEN'($urandom);
            flush     = ($urandom_range(0, 99) == 0);
            rst_l     = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_issue_scoreboard.md
# fpu_issue_scoreboard

Parametrised floating-point issue stage with an integrated FP register file and per-register scoreboard. It sits between the FP instruction decoder and the FP execution units. It accepts decoded operations, stalls on register hazards, tags every issued operation, and retires results arriving out of order on a tagged writeback port. Unlike the single-outstanding decode stage, it supports up to `MAX_OUT` in-flight operations with RAW writeback bypass.

## Interface
Parameters:
- `FPLEN`, 16: FP register and operand width.
- `NREGS`, 32: number of FP registers, power of two, ≥ 2. `AW = $clog2(NREGS)`.
- `MAX_OUT`, 4: maximum in-flight operations, ≥ 2. `TW = $clog2(MAX_OUT)`.

Ports:
- `clk`, in, 1: clock.
- `rst_l`, in, 1: reset; synchronous, active-low.
- `flush`, in, 1: discard all in-flight state.
- `dec_valid`, in, 1: decoded operation present.
- `dec_ready`, out, 1: operation accepted this cycle when `dec_valid` is also high.
- `dec_rden`, in, 3: read enables for {fs3, fs2, fs1}.
- `dec_fs1`, `dec_fs2`, `dec_fs3`, in, AW each: source addresses.
- `dec_fd`, in, AW: destination address.
- `dec_fd_we`, in, 1: operation writes `dec_fd`.
- `dec_op`, in, 24: opaque op/control bundle, passed through.
- `dec_rnd`, in, 3: rounding mode, passed through.
- `iss_valid`, out, 1: issue register holds an operation.
- `iss_ready`, in, 1: execution unit takes the operation.
- `iss_tag`, out, TW: tag of the issued operation.
- `iss_fs1`, `iss_fs2`, `iss_fs3`, out, FPLEN each: operands. Zero for a disabled source.
- `iss_op`, out, 24: registered `dec_op`.
- `iss_rnd`, out, 3: registered `dec_rnd`.
- `wb_valid`, in, 1: result return.
- `wb_tag`, in, TW: tag of the returning result.
- `wb_data`, in, FPLEN: result data.
- `wb_err`, out, 1: one-cycle pulse when a writeback hits an unallocated tag.
- `outstanding`, out, $clog2(MAX_OUT+1): count of allocated tags.

## Operation
Storage:
- `regs[NREGS]` of FPLEN bits.
- `busy[NREGS]`.
- Tag table of MAX_OUT entries, each {valid, fd, we}.

Hazard logic:
- A source RAW hazard exists when its `dec_rden` bit is set, its register is busy, and it is not being written this cycle (`wb_valid`, valid tag, we, fd matches the source).
- A WAW hazard exists when `dec_fd_we` is set and `busy[dec_fd]` is set. WAW hazards have no bypass.
- `tag_free` is true when any tag entry is invalid. It uses current-cycle valid bits only, so a tag freed by writeback is reusable the next cycle.
- `dec_ready = ~flush & ~RAW & ~WAW & tag_free & (~iss_valid | iss_ready)`.

Accept (`dec_valid & dec_ready`):
- Allocate the lowest-index free tag and write {1, dec_fd, dec_fd_we} into it.
- If `dec_fd_we`, set `busy[dec_fd]`.
- Load the issue register with the operands (regfile read, with the writeback value bypassed when it targets that source), op, rnd and tag. A disabled source loads 0.

Issue register:
- The occupant is held stable while `iss_valid & ~iss_ready`.
- It is cleared when `iss_ready` is high and there is no new accept.

Writeback (`wb_valid`, entry `wb_tag` valid):
- If the entry's we is set, write `regs[fd] <= wb_data` and clear `busy[fd]`.
- Invalidate the entry.
- A writeback to an invalid tag changes no state and pulses `wb_err` on the next cycle.

Simultaneous events:
- Accept and writeback in the same cycle are both applied.
- Busy clear and busy set of the same register in one cycle are impossible, because a busy `dec_fd` is a WAW stall.

`outstanding`: +1 on accept, −1 on valid writeback, unchanged when both occur.

`flush`:
- Next cycle: all busy bits and tag valids are 0, `iss_valid` = 0 and `outstanding` = 0.
- Regfile contents are kept.
- Same-cycle writeback is ignored, with no `wb_err`.

## Timing
- Reset values (next edge with `rst_l` = 0): `regs` all 0, `busy` 0, tags invalid, `iss_valid` 0, `iss_*` 0, `wb_err` 0, `outstanding` 0.
- `dec_ready` is 0 during reset.
- Reset asserted mid-operation drops all in-flight operations; later writebacks of old tags raise `wb_err`.
- Decode-to-issue latency is 1 cycle: accept at edge N gives `iss_valid` = 1 after edge N.
- Throughput is 1 operation/cycle with no hazards and `iss_ready` = 1.
- Writeback-to-regfile update: 1 edge.
- A RAW-dependent operation issues in the same cycle as its producer's writeback, via the bypass.
- A WAW-dependent operation is accepted 1 cycle after its producer's writeback.
- `dec_ready`, hazard and bypass logic are combinational; all other outputs are registered.

## Test plan
- Reset: hold `rst_l` = 0 for 2 cycles → `iss_valid` = 0, `outstanding` = 0, `dec_ready` = 0. Then release with `dec_valid` = 1 and no hazards → `dec_ready` = 1.
- Back-to-back independent ops: 4 ops with fd = 1, 2, 3, 4 and `iss_ready` = 1 → tags 0, 1, 2, 3 in order. The 5th op stalls (`dec_ready` = 0, `outstanding` = 4) until any writeback. It is then accepted the following cycle with the freed tag.
- RAW bypass: op A writes f5 (tag 0), op B reads fs1 = f5. Stall until `wb_valid`, `wb_tag` = 0, `wb_data` = 16'h3C00 → B accepted that same cycle with `iss_fs1` = 16'h3C00.
- WAW: two ops both with fd = f7 → the second waits until the cycle after the first's writeback. Final `regs[7]` equals the second result.
- Backpressure and out-of-order completion: `iss_ready` = 0 for 3 cycles → `iss_*` stable and `dec_ready` = 0. Return tags 1 then 0 → both registers updated and `outstanding` returns to 0.
- Error and flush: a `wb_tag` with no allocated entry → `wb_err` = 1 for exactly 1 cycle, no regfile change. `flush` with 3 in flight → next cycle `outstanding` = 0, `busy` all 0, earlier register values intact.
